// File: rtl/ila_pkg.sv
// Shared state encoding and sizing helper for the ILA readout serializer.
package ila_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } smp_state_e;

  function automatic int unsigned words_per_sample(input int unsigned sample_w,
                                                   input int unsigned out_w);
    return (sample_w + out_w - 32'd1) / out_w;
  endfunction

endpackage

// File: rtl/smp_rd_delay.sv
// Delays the RAM read strobe by the RAM read latency to mark the cycle in which
// the read data is valid on the RAM port.
module smp_rd_delay #(
  parameter int unsigned LATENCY = 1
) (
  input  logic i_clk_ILA,
  input  logic i_reset,
  input  logic i_read_active,
  input  logic i_rd,
  output logic o_capture
);

  logic [LATENCY-1:0] pipe_r;

  // Strobe pipeline; flushed on abort so a dropped read never captures later.
  always_ff @(posedge i_clk_ILA or negedge i_reset) begin
    if (!i_reset) begin
      pipe_r <= '0;
    end else if (!i_read_active) begin
      pipe_r <= '0;
    end else begin
      pipe_r[0] <= i_rd;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign o_capture = pipe_r[LATENCY-1];

endmodule

// File: rtl/smp_serializer.sv
// Readout serializer: fetches capture-RAM samples and streams them as OUT_WIDTH-bit
// words over valid/ready. Define SMP_SER_SEQ_TAG_EN to prefix each sample with its index.
module smp_serializer
  import ila_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 24,
  parameter int unsigned OUT_WIDTH    = 8,
  parameter bit          MSB_FIRST    = 1'b0,
  parameter int unsigned RAM_LATENCY  = 1,
  parameter int unsigned CNT_WIDTH    = 12
) (
  input  logic                    i_clk_ILA,
  input  logic                    i_reset,
  input  logic                    i_read_active,
  input  logic [CNT_WIDTH-1:0]    i_num_samples,
  output logic                    o_rd,
  input  logic [SAMPLE_WIDTH-1:0] i_ram_sample,
  output logic [OUT_WIDTH-1:0]    o_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_done
);

  localparam int unsigned WORDS = words_per_sample(SAMPLE_WIDTH, OUT_WIDTH);
  localparam int unsigned PAD_W = WORDS * OUT_WIDTH;
`ifdef SMP_SER_SEQ_TAG_EN
  localparam int unsigned TOT_WORDS = WORDS + 1;
`else
  localparam int unsigned TOT_WORDS = WORDS;
`endif
  localparam int unsigned TOT_W  = TOT_WORDS * OUT_WIDTH;
  localparam int unsigned WCNT_W = (TOT_WORDS > 1) ? $clog2(TOT_WORDS) : 1;
  localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(TOT_WORDS - 1);

  smp_state_e            state_r,  state_nx_s;
  logic [CNT_WIDTH-1:0]  n_r,      n_nx_s;
  logic [CNT_WIDTH-1:0]  cnt_r,    cnt_nx_s;
  logic [WCNT_W-1:0]     wcnt_r,   wcnt_nx_s;
  logic [TOT_W-1:0]      shreg_r,  shreg_nx_s;
  logic                  valid_r,  valid_nx_s;
  logic                  rd_r,     rd_nx_s;
  logic                  done_r,   done_nx_s;
  logic                  cap_s;
  logic                  xfer_s;
  logic [CNT_WIDTH-1:0]  cnt_inc_s;
  logic [PAD_W-1:0]      pad_s;
  logic [TOT_W-1:0]      load_s;

  smp_rd_delay #(.LATENCY(RAM_LATENCY)) u_rd_delay (
    .i_clk_ILA    (i_clk_ILA),
    .i_reset      (i_reset),
    .i_read_active(i_read_active),
    .i_rd         (rd_r),
    .o_capture    (cap_s)
  );

  assign xfer_s    = valid_r & i_ready;
  assign cnt_inc_s = cnt_r + CNT_WIDTH'(1'b1);
  assign pad_s     = PAD_W'(i_ram_sample);

`ifdef SMP_SER_SEQ_TAG_EN
  logic [OUT_WIDTH-1:0] tag_s;
  assign tag_s  = OUT_WIDTH'(cnt_r);
  // Tag occupies the word that leaves first in either word order.
  assign load_s = MSB_FIRST ? {tag_s, pad_s} : {pad_s, tag_s};
`else
  assign load_s = pad_s;
`endif

  // Next-state and next-register computation.
  always_comb begin
    state_nx_s = state_r;
    n_nx_s     = n_r;
    cnt_nx_s   = cnt_r;
    wcnt_nx_s  = wcnt_r;
    shreg_nx_s = shreg_r;
    valid_nx_s = valid_r;
    rd_nx_s    = 1'b0;
    done_nx_s  = done_r;
    if (!i_read_active) begin
      state_nx_s = ST_IDLE;
      n_nx_s     = '0;
      cnt_nx_s   = '0;
      wcnt_nx_s  = '0;
      shreg_nx_s = '0;
      valid_nx_s = 1'b0;
      done_nx_s  = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          n_nx_s   = i_num_samples;
          cnt_nx_s = '0;
          if (i_num_samples == '0) begin
            state_nx_s = ST_DONE;
            done_nx_s  = 1'b1;
          end else begin
            state_nx_s = ST_FETCH;
            rd_nx_s    = 1'b1;
          end
        end
        ST_FETCH: begin
          if (cap_s) begin
            shreg_nx_s = load_s;
            wcnt_nx_s  = '0;
            valid_nx_s = 1'b1;
            state_nx_s = ST_SHIFT;
          end else begin
            valid_nx_s = 1'b0;
          end
        end
        ST_SHIFT: begin
          if (xfer_s && (wcnt_r == WLAST)) begin
            wcnt_nx_s  = '0;
            cnt_nx_s   = cnt_inc_s;
            shreg_nx_s = '0;
            valid_nx_s = 1'b0;
            if (cnt_inc_s == n_r) begin
              state_nx_s = ST_DONE;
              done_nx_s  = 1'b1;
            end else begin
              state_nx_s = ST_FETCH;
              rd_nx_s    = 1'b1;
            end
          end else if (xfer_s) begin
            wcnt_nx_s  = wcnt_r + WCNT_W'(1'b1);
            shreg_nx_s = MSB_FIRST ? (shreg_r << OUT_WIDTH) : (shreg_r >> OUT_WIDTH);
          end else begin
            valid_nx_s = 1'b1;
          end
        end
        ST_DONE: begin
          done_nx_s  = 1'b1;
          valid_nx_s = 1'b0;
        end
        default: begin
          state_nx_s = ST_IDLE;
          valid_nx_s = 1'b0;
          done_nx_s  = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk_ILA or negedge i_reset) begin
    if (!i_reset) begin
      state_r <= ST_IDLE;
      n_r     <= '0;
      cnt_r   <= '0;
      wcnt_r  <= '0;
      shreg_r <= '0;
      valid_r <= 1'b0;
      rd_r    <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      n_r     <= n_nx_s;
      cnt_r   <= cnt_nx_s;
      wcnt_r  <= wcnt_nx_s;
      shreg_r <= shreg_nx_s;
      valid_r <= valid_nx_s;
      rd_r    <= rd_nx_s;
      done_r  <= done_nx_s;
    end
  end

  assign o_data  = MSB_FIRST ? shreg_r[TOT_W-1 -: OUT_WIDTH] : shreg_r[OUT_WIDTH-1:0];
  assign o_valid = valid_r;
  assign o_rd    = rd_r;
  assign o_done  = done_r;

endmodule

// File: tb/tb_smp_serializer.sv
// Scoreboard bench for smp_serializer: instance A (24/8, LSB first, latency 1) and
// instance B (10/4, MSB first, latency 3), each with a queue-fed RAM model.
module tb_smp_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ra_a = 1'b0, rdy_a = 1'b0, rd_a, valid_a, done_a;
  logic [11:0] num_a = 12'd0;
  logic [23:0] pa = 24'd0;
  logic [7:0]  data_a;
  logic        ra_b = 1'b0, rdy_b = 1'b0, rd_b, valid_b, done_b;
  logic [11:0] num_b = 12'd0;
  logic [9:0]  pb [0:2];
  logic [3:0]  data_b;

  smp_serializer #(.SAMPLE_WIDTH(24), .OUT_WIDTH(8), .MSB_FIRST(1'b0), .RAM_LATENCY(1), .CNT_WIDTH(12)) u_a (
    .i_clk_ILA(clk), .i_reset(rst_n), .i_read_active(ra_a), .i_num_samples(num_a),
    .o_rd(rd_a), .i_ram_sample(pa), .o_data(data_a), .o_valid(valid_a),
    .i_ready(rdy_a), .o_done(done_a));

  smp_serializer #(.SAMPLE_WIDTH(10), .OUT_WIDTH(4), .MSB_FIRST(1'b1), .RAM_LATENCY(3), .CNT_WIDTH(12)) u_b (
    .i_clk_ILA(clk), .i_reset(rst_n), .i_read_active(ra_b), .i_num_samples(num_b),
    .o_rd(rd_b), .i_ram_sample(pb[2]), .o_data(data_b), .o_valid(valid_b),
    .i_ready(rdy_b), .o_done(done_b));

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int rdc_a   = 0;
  int rdc_b   = 0;
  logic [23:0] ramq_a [$];
  logic [9:0]  ramq_b [$];
  logic [7:0]  qa [$];
  logic [3:0]  qb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // RAM models: a read pops the next queued sample, data appears after the latency.
  always @(posedge clk) begin
    if (rd_a) begin
      rdc_a <= rdc_a + 1;
      if (ramq_a.size() > 0) pa <= ramq_a.pop_front();
      else pa <= 24'hDEAD00;
    end else begin
      pa <= 24'hDEAD00;
    end
    if (rd_b) begin
      rdc_b <= rdc_b + 1;
      if (ramq_b.size() > 0) pb[0] <= ramq_b.pop_front();
      else pb[0] <= 10'h2DE;
    end else begin
      pb[0] <= 10'h2DE;
    end
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end

  // Monitors: scoreboard pops, stall stability, read-to-valid latency.
  int          rd_cyc_a = 0, rd_cyc_b = 0;
  logic        vprev_a = 1'b0, vprev_b = 1'b0, stall_a = 1'b0, stall_b = 1'b0;
  logic [7:0]  dprev_a = 8'd0;
  logic [3:0]  dprev_b = 4'd0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_a) begin
        check("stall_valid_a", {31'd0, valid_a}, 32'd1);
        check("stall_data_a", {24'd0, data_a}, {24'd0, dprev_a});
      end
      if (stall_b) begin
        check("stall_valid_b", {31'd0, valid_b}, 32'd1);
        check("stall_data_b", {28'd0, data_b}, {28'd0, dprev_b});
      end
      if (valid_a && rdy_a) begin
        if (qa.size() == 0) check("extra_word_a", {24'd0, data_a}, 32'hFFFF_FFFF);
        else check("word_a", {24'd0, data_a}, {24'd0, qa.pop_front()});
      end
      if (valid_b && rdy_b) begin
        if (qb.size() == 0) check("extra_word_b", {28'd0, data_b}, 32'hFFFF_FFFF);
        else check("word_b", {28'd0, data_b}, {28'd0, qb.pop_front()});
      end
      if (rd_a) rd_cyc_a = cyc;
      if (rd_b) rd_cyc_b = cyc;
      if (valid_a && !vprev_a) check("latency_a", cyc - rd_cyc_a, 32'd2);
      if (valid_b && !vprev_b) check("latency_b", cyc - rd_cyc_b, 32'd4);
    end
    vprev_a = valid_a;
    vprev_b = valid_b;
    stall_a = valid_a && !rdy_a && ra_a;
    stall_b = valid_b && !rdy_b && ra_b;
    dprev_a = data_a;
    dprev_b = data_b;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input int idx, input logic [23:0] s);
`ifdef SMP_SER_SEQ_TAG_EN
    qa.push_back(8'(idx));
`endif
    for (int w = 0; w < 3; w++) qa.push_back(s[8*w +: 8]);
    ramq_a.push_back(s);
  endtask

  task automatic push_b(input int idx, input logic [9:0] s);
    logic [11:0] pad;
    pad = {2'b00, s};
`ifdef SMP_SER_SEQ_TAG_EN
    qb.push_back(4'(idx));
`endif
    for (int w = 2; w >= 0; w--) qb.push_back(pad[4*w +: 4]);
    ramq_b.push_back(s);
  endtask

  task automatic wait_done_a(input string name);
    for (int i = 0; i < 300 && !done_a; i++) step();
    check(name, {31'd0, done_a}, 32'd1);
  endtask

  task automatic toggle_wait_done_a(input string name);
    for (int i = 0; i < 300 && !done_a; i++) begin
      rdy_a = ~rdy_a;
      step();
    end
    check(name, {31'd0, done_a}, 32'd1);
  endtask

  task automatic end_readout_a();
    ra_a = 1'b0;
    rdy_a = 1'b0;
    step();
    step();
    check("done_clear_a", {31'd0, done_a}, 32'd0);
    check("drain_a", qa.size(), 32'd0);
  endtask

  int base;

  initial begin
    pb[0] = 10'd0; pb[1] = 10'd0; pb[2] = 10'd0;
    #12;
    check("rst_data_a", {24'd0, data_a}, 32'd0);
    check("rst_ctrl_a", {29'd0, valid_a, rd_a, done_a}, 32'd0);
    check("rst_ctrl_b", {25'd0, data_b, valid_b, rd_b, done_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Two 24-bit samples, LSB word first, consumer always ready.
    base = rdc_a;
    push_a(0, 24'hA1B2C3);
    push_a(1, 24'h112233);
    num_a = 12'd2; rdy_a = 1'b1; ra_a = 1'b1;
    wait_done_a("done_t1");
    step();
    check("done_held_t1", {31'd0, done_a}, 32'd1);
    check("rd_count_t1", rdc_a - base, 32'd2);
    end_readout_a();

    // Consumer toggles ready every cycle.
    base = rdc_a;
    push_a(0, 24'h5A6B7C);
    num_a = 12'd1; ra_a = 1'b1;
    toggle_wait_done_a("done_t3");
    check("rd_count_t3", rdc_a - base, 32'd1);
    end_readout_a();

    // Abort after the first word of the second sample, then restart with N=1.
    push_a(0, 24'h010203);
    push_a(1, 24'h040506);
    num_a = 12'd2; rdy_a = 1'b1; ra_a = 1'b1;
    for (int i = 0; i < 300 && qa.size() != (qa.size() > 4 ? 0 : 2); i++) step();
    check("abort_point_t5", qa.size(), 32'd2);
    ra_a = 1'b0; rdy_a = 1'b0;
    qa.delete();
    ramq_a.delete();
    step();
    step();
    check("abort_clear_t5", {29'd0, valid_a, rd_a, done_a}, 32'd0);
    base = rdc_a;
    push_a(0, 24'h0A0B0C);
    num_a = 12'd1; rdy_a = 1'b1; ra_a = 1'b1;
    wait_done_a("done_t5");
    check("rd_count_t5", rdc_a - base, 32'd1);
    end_readout_a();

    // N=0 goes straight to DONE with no read and no word.
    base = rdc_a;
    num_a = 12'd0; rdy_a = 1'b1; ra_a = 1'b1;
    step();
    check("zero_done_t6", {31'd0, done_a}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("zero_quiet_t6", {30'd0, valid_a, rd_a}, 32'd0);
    end
    check("zero_rd_t6", rdc_a - base, 32'd0);
    end_readout_a();

    // Three samples (tags 0,1,2 when the tag option is built in).
    base = rdc_a;
    push_a(0, 24'hFFEE01);
    push_a(1, 24'h000000);
    push_a(2, 24'h7F8081);
    num_a = 12'd3; rdy_a = 1'b1; ra_a = 1'b1;
    wait_done_a("done_t6b");
    check("rd_count_t6b", rdc_a - base, 32'd3);
    end_readout_a();

    // Instance B: 10-bit samples in 4-bit words, MSB first, latency 3.
    base = rdc_b;
    push_b(0, 10'h3FF);
    push_b(1, 10'h2A5);
    num_b = 12'd2; rdy_b = 1'b1; ra_b = 1'b1;
    for (int i = 0; i < 300 && !done_b; i++) step();
    check("done_b", {31'd0, done_b}, 32'd1);
    check("rd_count_b", rdc_b - base, 32'd2);
    ra_b = 1'b0;
    step();
    step();
    check("done_clear_b", {31'd0, done_b}, 32'd0);
    check("drain_b", qb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
